// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: req/ack data-memory access, timeout and sticky error flags
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [31:0] pc_target,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic [1:0]  mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [1:0]  wb_mem_to_reg,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_target,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc_target;
  logic [4:0]  lat_rd;
  logic        lat_we;
  logic        lat_reg_write;
  logic [1:0]  lat_mem_to_reg;

  logic capture;
  logic is_mem_op;
  logic aligned;
  logic wait_ack;
  logic wait_timeout;

  assign capture   = (state == IDLE) && in_valid && !flush;
  assign is_mem_op = mem_write || (mem_to_reg == 2'b01);
  assign aligned   = (alu_result[1:0] == 2'b00);

  // Memory-port outputs depend only on state and latched registers.
  assign in_ready   = (state == IDLE);
  assign dmem_req   = (state == WAIT);
  assign dmem_we    = (state == WAIT) && lat_we;
  assign dmem_addr  = lat_addr;
  assign dmem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    wait_ack     = 1'b0;
    wait_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (capture && is_mem_op && aligned) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A late ack in the final allowed cycle still completes normally.
        if (dmem_ack) begin
          wait_ack   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          wait_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt       <= 8'd0;
      lat_addr       <= 32'd0;
      lat_wdata      <= 32'd0;
      lat_pc_target  <= 32'd0;
      lat_rd         <= 5'd0;
      lat_we         <= 1'b0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 2'b00;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 2'b00;
      wb_alu_result  <= 32'd0;
      wb_read_data   <= 32'd0;
      wb_pc_target   <= 32'd0;
      err_misalign   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;

      if (capture) begin
        if (is_mem_op && aligned) begin
          lat_addr       <= alu_result;
          lat_wdata      <= write_data;
          lat_pc_target  <= pc_target;
          lat_rd         <= rd;
          lat_we         <= mem_write;
          lat_reg_write  <= reg_write;
          lat_mem_to_reg <= mem_to_reg;
          wait_cnt       <= 8'd0;
        end else begin
          // Non-memory op, or a misaligned access retired without a request.
          wb_valid      <= 1'b1;
          wb_rd         <= rd;
          wb_reg_write  <= is_mem_op ? 1'b0 : reg_write;
          wb_mem_to_reg <= mem_to_reg;
          wb_alu_result <= alu_result;
          wb_read_data  <= 32'd0;
          wb_pc_target  <= pc_target;
          if (is_mem_op) begin
            err_misalign <= 1'b1;
          end
        end
      end

      if (state == WAIT) begin
        if (wait_ack || wait_timeout) begin
          wb_valid      <= 1'b1;
          wb_rd         <= lat_rd;
          wb_reg_write  <= wait_ack && lat_reg_write;
          wb_mem_to_reg <= lat_mem_to_reg;
          wb_alu_result <= lat_addr;
          wb_read_data  <= (wait_ack && !lat_we) ? dmem_rdata : 32'd0;
          wb_pc_target  <= lat_pc_target;
          if (wait_timeout) begin
            err_timeout <= 1'b1;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] pc_target;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_write;
  logic [1:0]  mem_to_reg;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [1:0]  wb_mem_to_reg;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_read_data;
  logic [31:0] wb_pc_target;
  logic        err_misalign;
  logic        err_timeout;

  int nchk = 0;
  int nerr = 0;

  mem_access_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_result(alu_result), .write_data(write_data), .pc_target(pc_target), .rd(rd),
    .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result),
    .wb_read_data(wb_read_data), .wb_pc_target(wb_pc_target),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pct;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  m2r;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pct;
    int          reqs;
    bit          misal;
    bit          tmo;
  } exp_t;

  // Reference: what retires for an instruction whose ack comes after k empty wait cycles.
  function automatic exp_t predict(input instr_t i, input int k, input logic [31:0] word);
    exp_t e;
    bit is_mem;
    is_mem  = i.mw || (i.m2r == 2'b01);
    e.misal = is_mem && (i.alu[1:0] != 2'b00);
    e.tmo   = is_mem && !e.misal && (k >= TMO);
    e.reqs  = (!is_mem || e.misal) ? 0 : (e.tmo ? TMO : k + 1);
    e.rd    = i.rd;
    e.m2r   = i.m2r;
    e.alu   = i.alu;
    e.pct   = i.pct;
    e.rw    = i.rw && !e.misal && !e.tmo;
    e.rdata = (is_mem && !i.mw && !e.misal && !e.tmo) ? word : 32'd0;
    return e;
  endfunction

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                                input logic rw, input logic mw, input logic [1:0] m2r);
    instr_t i;
    i.alu = a; i.wd = wd; i.pct = $urandom; i.rd = r; i.rw = rw; i.mw = mw; i.m2r = m2r;
    return i;
  endfunction

  function automatic instr_t gen_instr();
    instr_t i;
    int kind;
    logic [1:0] alu_sel [3];
    alu_sel[0] = 2'b00; alu_sel[1] = 2'b10; alu_sel[2] = 2'b11;
    kind = $urandom_range(0, 4);
    i = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 2'b00);
    case (kind)
      0, 1: i.m2r = alu_sel[$urandom_range(0, 2)];
      2: begin i.m2r = 2'b01; i.alu[1:0] = 2'b00; end
      3: begin i.mw = 1'b1; i.m2r = 2'($urandom); i.alu[1:0] = 2'b00; end
      default: begin
        i.mw = 1'($urandom); i.m2r = 2'b01;
        i.alu[1:0] = 2'($urandom_range(1, 3));
      end
    endcase
    return i;
  endfunction

  task automatic offer(input instr_t i);
    alu_result = i.alu; write_data = i.wd; pc_target = i.pct; rd = i.rd;
    reg_write = i.rw; mem_write = i.mw; mem_to_reg = i.m2r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    offer(mk(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 2'b00));
    tick(); tick();
    nchk++; if (in_ready !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      nerr++; $display("FAIL reset_port: got ready=%b req=%b we=%b expected 1 0 0", in_ready, dmem_req, dmem_we);
    end
    nchk++; if ({dmem_addr, dmem_wdata} !== 64'd0) begin
      nerr++; $display("FAIL reset_addr: got %h %h expected 0 0", dmem_addr, dmem_wdata);
    end
    nchk++; if ({wb_valid, wb_rd, wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_read_data, wb_pc_target,
                 err_misalign, err_timeout} !== '0) begin
      nerr++; $display("FAIL reset_wb: got valid=%b rd=%0d alu=%h rdata=%h pct=%h errs=%b%b expected all 0",
                       wb_valid, wb_rd, wb_alu_result, wb_read_data, wb_pc_target, err_misalign, err_timeout);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    instr_t i;
    offer(mk(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nchk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_alu_result !== 32'h1234 || wb_reg_write !== 1'b1) begin
      nerr++; $display("FAIL alu_basic: got valid=%b rd=%0d alu=%h rw=%b expected 1 5 00001234 1",
                       wb_valid, wb_rd, wb_alu_result, wb_reg_write);
    end
    nchk++; if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      nerr++; $display("FAIL alu_ready: got ready=%b req=%b expected 1 0", in_ready, dmem_req);
    end
    // Back-to-back non-memory ops retire one per cycle.
    for (int n = 0; n < 8; n++) begin
      i = gen_instr();
      i.mw = 1'b0;
      if (i.m2r == 2'b01) i.m2r = 2'b10;
      offer(i);
      in_valid = 1'b1;
      tick();
      nchk++; if (wb_valid !== 1'b1 || wb_rd !== i.rd || wb_reg_write !== i.rw || wb_mem_to_reg !== i.m2r ||
                   wb_alu_result !== i.alu || wb_pc_target !== i.pct || wb_read_data !== 32'd0 || in_ready !== 1'b1) begin
        nerr++; $display("FAIL alu_b2b: got valid=%b rd=%0d alu=%h pct=%h m2r=%b expected 1 %0d %h %h %b",
                         wb_valid, wb_rd, wb_alu_result, wb_pc_target, wb_mem_to_reg, i.rd, i.alu, i.pct, i.m2r);
      end
    end
    in_valid = 1'b0;
    tick();
    nchk++; if (wb_valid !== 1'b0) begin
      nerr++; $display("FAIL alu_idle: got wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_load();
    offer(mk(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      nchk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || in_ready !== 1'b0 || dmem_addr !== 32'h100 || wb_valid !== 1'b0) begin
        nerr++; $display("FAIL load_wait%0d: got req=%b we=%b ready=%b addr=%h wbv=%b expected 1 0 0 00000100 0",
                         c, dmem_req, dmem_we, in_ready, dmem_addr, wb_valid);
      end
      dmem_ack = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      tick();
      dmem_ack = 1'b0;
    end
    nchk++; if (wb_valid !== 1'b1 || wb_read_data !== 32'hDEADBEEF || wb_mem_to_reg !== 2'b01 || wb_rd !== 5'd7 ||
                 in_ready !== 1'b1 || dmem_req !== 1'b0) begin
      nerr++; $display("FAIL load_done: got valid=%b rdata=%h m2r=%b rd=%0d ready=%b req=%b expected 1 deadbeef 01 7 1 0",
                       wb_valid, wb_read_data, wb_mem_to_reg, wb_rd, in_ready, dmem_req);
    end
    tick();
    nchk++; if (wb_valid !== 1'b0) begin
      nerr++; $display("FAIL load_pulse: got wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_store_b2b();
    instr_t a;
    offer(mk(32'h200, 32'hCAFEF00D, 5'd3, 1'b0, 1'b1, 2'b00));
    in_valid = 1'b1;
    tick();
    nchk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'hCAFEF00D || in_ready !== 1'b0) begin
      nerr++; $display("FAIL store_req: got req=%b we=%b wdata=%h ready=%b expected 1 1 cafef00d 0",
                       dmem_req, dmem_we, dmem_wdata, in_ready);
    end
    a = mk(32'h5555AAAA, 32'h0, 5'd9, 1'b1, 1'b0, 2'b10);
    offer(a);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    nchk++; if (wb_valid !== 1'b1 || wb_read_data !== 32'd0 || wb_alu_result !== 32'h200 || in_ready !== 1'b1 || dmem_we !== 1'b0) begin
      nerr++; $display("FAIL store_done: got valid=%b rdata=%h alu=%h ready=%b we=%b expected 1 0 00000200 1 0",
                       wb_valid, wb_read_data, wb_alu_result, in_ready, dmem_we);
    end
    tick();
    in_valid = 1'b0;
    nchk++; if (wb_valid !== 1'b1 || wb_alu_result !== a.alu || wb_rd !== 5'd9 || wb_pc_target !== a.pct) begin
      nerr++; $display("FAIL store_next_alu: got valid=%b alu=%h rd=%0d expected 1 %h 9", wb_valid, wb_alu_result, wb_rd, a.alu);
    end
  endtask

  task automatic test_misalign();
    offer(mk(32'h103, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nchk++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || err_misalign !== 1'b1 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL misalign: got req=%b valid=%b rw=%b err=%b ready=%b expected 0 1 0 1 1",
                       dmem_req, wb_valid, wb_reg_write, err_misalign, in_ready);
    end
    tick();
    nchk++; if (dmem_req !== 1'b0 || err_misalign !== 1'b1) begin
      nerr++; $display("FAIL misalign_sticky: got req=%b err=%b expected 0 1", dmem_req, err_misalign);
    end
  endtask

  task automatic test_timeout();
    int reqc;
    offer(mk(32'h40, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reqc = 0;
    while (dmem_req === 1'b1 && reqc < 3 * TMO) begin
      if (reqc == TMO - 1) begin
        nchk++; if (err_timeout !== 1'b0 || wb_valid !== 1'b0) begin
          nerr++; $display("FAIL tmo_early: got err=%b valid=%b expected 0 0", err_timeout, wb_valid);
        end
      end
      reqc++;
      tick();
    end
    nchk++; if (reqc !== TMO || err_timeout !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_read_data !== 32'd0) begin
      nerr++; $display("FAIL tmo: got reqs=%0d err=%b valid=%b rw=%b rdata=%h expected %0d 1 1 0 0",
                       reqc, err_timeout, wb_valid, wb_reg_write, wb_read_data, TMO);
    end
    offer(mk(32'h44, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5F00F;
    tick();
    dmem_ack = 1'b0;
    nchk++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_read_data !== 32'hA5A5F00F || err_timeout !== 1'b1) begin
      nerr++; $display("FAIL tmo_recover: got valid=%b rw=%b rdata=%h err=%b expected 1 1 a5a5f00f 1",
                       wb_valid, wb_reg_write, wb_read_data, err_timeout);
    end
  endtask

  task automatic test_flush_wait();
    offer(mk(32'h80, 32'h0, 5'd12, 1'b1, 1'b0, 2'b01));
    in_valid = 1'b1;
    tick();
    offer(mk(32'h9999, 32'h0, 5'd30, 1'b1, 1'b0, 2'b00));
    flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h0F0F1234;
    tick();
    dmem_ack = 1'b0;
    nchk++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_read_data !== 32'h0F0F1234 || wb_alu_result !== 32'h80) begin
      nerr++; $display("FAIL flush_wait: got valid=%b rd=%0d rdata=%h alu=%h expected 1 12 0f0f1234 00000080",
                       wb_valid, wb_rd, wb_read_data, wb_alu_result);
    end
    tick();
    nchk++; if (wb_valid !== 1'b0) begin
      nerr++; $display("FAIL flush_dropped: got wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    offer(mk(32'h300, 32'h77, 5'd2, 1'b1, 1'b1, 2'b00));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    nchk++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || {dmem_addr, dmem_wdata} !== 64'd0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL rst_wait_port: got req=%b we=%b addr=%h ready=%b expected 0 0 0 1",
                       dmem_req, dmem_we, dmem_addr, in_ready);
    end
    nchk++; if ({wb_valid, wb_rd, wb_reg_write, wb_alu_result, wb_read_data, wb_pc_target, err_misalign, err_timeout} !== '0) begin
      nerr++; $display("FAIL rst_wait_wb: got valid=%b alu=%h errs=%b%b expected all 0",
                       wb_valid, wb_alu_result, err_misalign, err_timeout);
    end
    #1;
    rst = 1'b1;
    tick();
    nchk++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || err_timeout !== 1'b0 || err_misalign !== 1'b0) begin
      nerr++; $display("FAIL rst_wait_after: got req=%b valid=%b errs=%b%b expected 0 0 00",
                       dmem_req, wb_valid, err_misalign, err_timeout);
    end
  endtask

  task automatic test_random();
    instr_t i;
    instr_t junk;
    exp_t   e;
    int     k;
    int     reqc;
    int     cyc;
    logic [31:0] word;
    bit     exp_mis;
    bit     exp_tmo;
    exp_mis = 1'b0;
    exp_tmo = 1'b0;
    for (int n = 0; n < 60; n++) begin
      i = gen_instr();
      k = $urandom_range(0, TMO + 1);
      word = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        junk = gen_instr();
        offer(junk);
        in_valid = 1'b1; flush = 1'b1; dmem_ack = 1'($urandom);
        tick();
        nchk++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
          nerr++; $display("FAIL rnd_bubble: got valid=%b req=%b ready=%b expected 0 0 1", wb_valid, dmem_req, in_ready);
        end
      end
      offer(i);
      in_valid = 1'b1; flush = 1'b0;
      dmem_ack = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      tick();
      in_valid = 1'b0; dmem_ack = 1'b0;
      e = predict(i, k, word);
      exp_mis |= e.misal;
      exp_tmo |= e.tmo;
      reqc = 0;
      cyc = 0;
      while (wb_valid !== 1'b1 && cyc < TMO + 4) begin
        nchk++; if (dmem_req !== 1'b1 || dmem_addr !== i.alu || dmem_we !== i.mw || dmem_wdata !== i.wd || in_ready !== 1'b0) begin
          nerr++; $display("FAIL rnd_req: got req=%b addr=%h we=%b wdata=%h ready=%b expected 1 %h %b %h 0",
                           dmem_req, dmem_addr, dmem_we, dmem_wdata, in_ready, i.alu, i.mw, i.wd);
        end
        dmem_ack = (reqc == k);
        dmem_rdata = (reqc == k) ? word : $urandom;
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b1; flush = 1'b1;
        end
        reqc++;
        tick();
        dmem_ack = 1'b0; in_valid = 1'b0; flush = 1'b0;
        cyc++;
      end
      nchk++; if (wb_valid !== 1'b1 || reqc !== e.reqs) begin
        nerr++; $display("FAIL rnd_latency: got valid=%b reqs=%0d expected 1 %0d", wb_valid, reqc, e.reqs);
      end
      nchk++; if (wb_rd !== e.rd || wb_reg_write !== e.rw || wb_mem_to_reg !== e.m2r || wb_alu_result !== e.alu ||
                   wb_read_data !== e.rdata || wb_pc_target !== e.pct) begin
        nerr++; $display("FAIL rnd_wb: got rd=%0d rw=%b m2r=%b alu=%h rdata=%h pct=%h expected %0d %b %b %h %h %h",
                         wb_rd, wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_read_data, wb_pc_target,
                         e.rd, e.rw, e.m2r, e.alu, e.rdata, e.pct);
      end
      nchk++; if (err_misalign !== exp_mis || err_timeout !== exp_tmo || in_ready !== 1'b1 || dmem_req !== 1'b0) begin
        nerr++; $display("FAIL rnd_flags: got mis=%b tmo=%b ready=%b req=%b expected %b %b 1 0",
                         err_misalign, err_timeout, in_ready, dmem_req, exp_mis, exp_tmo);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_b2b();
    test_misalign();
    test_timeout();
    test_flush_wait();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline, downstream of the ID/EX register and EX ALU. Captures one executed instruction per cycle. Non-memory instructions pass to the MEM/WB side in one cycle. Loads and stores run a req/ack transaction on the data-memory port and stall upstream until it completes. Misaligned addresses and memory timeouts are flagged as sticky errors.

## Interface
- TIMEOUT, 16: maximum WAIT cycles without ack before the access is abandoned (1..255).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept; upstream holds all inputs while low.
- flush  in  1  discard the instruction offered this cycle.
- alu_result  in  32  ALU output; the memory address for loads and stores.
- write_data  in  32  store data (RD2).
- pc_target  in  32  pc_count+signImm computed upstream.
- rd  in  5  destination register.
- reg_write, mem_write  in  1  control bits.
- mem_to_reg  in  2  writeback select: 00 ALU, 01 load data, 10 pc_target, 11 treated as 00.
- dmem_req, dmem_we  out  1  memory request and write enable.
- dmem_addr, dmem_wdata  out  32  memory address and store data.
- dmem_rdata  in  32  load data, valid in the cycle dmem_ack=1.
- dmem_ack  in  1  single-cycle completion.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register write enable.
- wb_mem_to_reg  out  2  writeback select.
- wb_alu_result, wb_read_data, wb_pc_target  out  32  writeback operands.
- err_misalign, err_timeout  out  1  sticky error flags.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - WAIT: in_ready=0.
- A capture occurs at a posedge with state IDLE, in_valid=1 and flush=0. flush=1 with in_valid=1 is a bubble: nothing is captured and no output changes.
- Memory op: mem_write=1 or mem_to_reg=01. A store with mem_to_reg=01 is a store; no read data is captured.
- Non-memory capture: all wb_* fields are registered; wb_valid=1 next cycle; wb_read_data=0; state stays IDLE.
- Memory capture, alu_result[1:0]=00:
  - Latch address, data and control.
  - Go to WAIT and clear the wait counter.
- Memory capture, alu_result[1:0]≠00:
  - No request is issued; set err_misalign.
  - Retire next cycle with wb_reg_write=0; stay IDLE.
- In WAIT:
  - dmem_req=1; dmem_we=latched mem_write; dmem_addr and dmem_wdata held constant.
  - The counter increments each cycle that ack=0.
- ack=1 in WAIT:
  - Capture dmem_rdata into wb_read_data (loads only; stores leave it 0).
  - Pulse wb_valid next cycle with the latched control; return to IDLE.
- Counter reaches TIMEOUT with ack=0:
  - Drop dmem_req; set err_timeout.
  - Retire with wb_reg_write=0 and wb_read_data=0; return to IDLE.
- ack and timeout in the same cycle: ack wins, with normal completion.
- flush while in WAIT does not abort the in-flight access. It is older than the flushed instruction and completes normally.
- dmem_ack outside WAIT is ignored.
- Error flags clear only on reset.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, so in_ready=1.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - wb_valid=0 and all wb_* fields 0; counter 0; err flags 0.
- Reset asserted mid-WAIT: dmem_req drops immediately and the transaction is abandoned without error.
- Non-memory latency: 1 cycle from capture edge to wb_valid.
- Memory latency: capture edge N, dmem_req high from cycle N+1.
  - ack first sampled at edge N+1+k; wb_valid high in cycle N+2+k.
  - Minimum 2 cycles (k=0).
- Back-to-back: in_ready is low in every WAIT cycle and high again in the wb_valid cycle. An instruction offered in that cycle is captured, giving throughput of 1 instruction per cycle for non-memory ops.
- Timeout: dmem_req is high for exactly TIMEOUT cycles. wb_valid and err_timeout both rise in the cycle after the last req cycle.
- in_ready and dmem_* are functions of state and latched registers only; no combinational path from in_valid or dmem_ack.

## Test plan
- Reset, then an ALU op (alu_result=0x1234, rd=5, reg_write=1, mem_to_reg=00) -> next cycle wb_valid=1, wb_rd=5, wb_alu_result=0x1234, in_ready stays 1.
- Load from 0x100, ack after 3 wait cycles with rdata=0xDEADBEEF:
  - dmem_req=1 and dmem_we=0 for 4 cycles; in_ready=0 throughout.
  - wb_read_data=0xDEADBEEF, wb_mem_to_reg=01, wb_valid a single pulse.
- Store of 0xCAFEF00D to 0x200 with ack at k=0, followed immediately by an ALU op held at in_valid -> dmem_we=1 for one cycle, store retires, the ALU op is captured in the retire cycle.
- Load at 0x103 -> dmem_req never asserts; err_misalign=1; wb_valid with wb_reg_write=0 next cycle.
- TIMEOUT=4, no ack:
  - dmem_req high exactly 4 cycles, then err_timeout=1 and wb_valid with wb_reg_write=0.
  - The next load with ack succeeds normally and err_timeout stays 1.
- Mid-WAIT cases:
  - flush asserted mid-WAIT: the access still completes.
  - rst pulsed low mid-WAIT: dmem_req=0 immediately, all outputs 0, no err flag set.
